// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU sequencer: datapath widths, opcode
// constants, FSM state encoding and a small opcode classifier.
//
// With SEQ_SINGLE_STEP_EN defined the state encoding grows to 4 bits to
// make room for the STEP_WAIT state.
package cpu_pkg;

    localparam int OPCODE_W = 4;
    localparam int ADDR_W   = 12;
    localparam int CNT_W    = 16;

`ifdef SEQ_SINGLE_STEP_EN
    localparam int STATE_W = 4;
`else
    localparam int STATE_W = 3;
`endif

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = STATE_W'(0),
        ST_IFETCH  = STATE_W'(1),
        ST_LATCH   = STATE_W'(2),
        ST_DECODE  = STATE_W'(3),
        ST_EXEC    = STATE_W'(4),
        ST_MEMWAIT = STATE_W'(5),
        ST_WB      = STATE_W'(6),
        ST_HALT    = STATE_W'(7)
`ifdef SEQ_SINGLE_STEP_EN
        ,
        ST_STEP_WAIT = STATE_W'(8)
`endif
    } state_e;

    localparam logic [OPCODE_W-1:0] OP_NOP = 4'h0;
    localparam logic [OPCODE_W-1:0] OP_LDA = 4'h1;
    localparam logic [OPCODE_W-1:0] OP_STA = 4'h2;
    localparam logic [OPCODE_W-1:0] OP_ADD = 4'h3;
    localparam logic [OPCODE_W-1:0] OP_SUB = 4'h4;
    localparam logic [OPCODE_W-1:0] OP_JMP = 4'h5;
    localparam logic [OPCODE_W-1:0] OP_JZ  = 4'h6;
    localparam logic [OPCODE_W-1:0] OP_HLT = 4'hF;

    // Opcodes 7..E are unassigned.
    function automatic logic is_legal(input logic [OPCODE_W-1:0] op);
        return (op <= OP_JZ) || (op == OP_HLT);
    endfunction

endpackage

// File: rtl/seq_timeout.sv
// Loadable down-counter used as the memory-handshake watchdog.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (counter clears to 0)
//   load        load load_val (has priority over dec)
//   load_val    reload value
//   dec         count down by one; holds at zero
//   expired     count is zero (terminal count)
module seq_timeout #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         expired
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/cpu_sequencer.sv
// Control sequencer for a small accumulator CPU: fetch, decode, execute,
// data-memory access and write-back, with a memory-handshake watchdog.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   run                     level; allows leaving IDLE and continuing after WB
//   in_opcode               opcode from the fetch-stage register
//   acc_zero                accumulator-zero flag (JZ condition)
//   imem_req / imem_ready   instruction-memory read handshake
//   dmem_req, dmem_we /
//   dmem_ready              data-memory handshake (dmem_we=1 is a write)
//   fetch_ce, pc_inc        fetch-register load and PC increment (LATCH)
//   pc_load                 PC load from address (JMP, taken JZ)
//   alu_ce, acc_we          ALU operate / accumulator write
//   state                   current FSM state encoding
//   halted, fault, illegal  status (fault and illegal are sticky)
//   instr_count             retired-instruction counter, wraps
//   step                    single-step advance (only with SEQ_SINGLE_STEP_EN)
//
// Build option: define SEQ_SINGLE_STEP_EN to add the step input and the
// STEP_WAIT state; WB then waits for a rising edge of step instead of run.
//
// State      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | waiting for run
// IFETCH     | imem_req held until imem_ready (watchdog armed)
// LATCH      | load fetch register, advance PC
// DECODE     | classify opcode, flag illegal opcodes (executed as NOP)
// EXEC       | branch strobes, or dispatch to MEMWAIT / HALT / WB
// MEMWAIT    | dmem_req held until dmem_ready (watchdog armed)
// WB         | retire: instr_count + 1
// HALT       | HLT or watchdog fault; exit only through reset
// STEP_WAIT  | single-step builds only: wait for rising edge of step
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int               MEM_TIMEOUT = 15,
    // Reset value of instr_count; 0 for normal use.
    parameter logic [CNT_W-1:0] CNT_PRESET  = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    input  logic [OPCODE_W-1:0] in_opcode,
    input  logic                acc_zero,
    input  logic                imem_ready,
    input  logic                dmem_ready,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic                step,
`endif
    output logic                imem_req,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic                fetch_ce,
    output logic                pc_inc,
    output logic                pc_load,
    output logic                alu_ce,
    output logic                acc_we,
    output logic [STATE_W-1:0]  state,
    output logic                halted,
    output logic                fault,
    output logic                illegal,
    output logic [CNT_W-1:0]    instr_count
);

    localparam int              TO_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(MEM_TIMEOUT - 1);

    state_e                state_q, state_d;
    logic [OPCODE_W-1:0]   op_q;
    logic                  illegal_q;
    logic                  fault_q;
    logic [CNT_W-1:0]      count_q;
    logic                  timeout_hit;
    logic                  to_load;
    logic                  to_dec;
    logic                  to_expired;
    logic                  waiting;

`ifdef SEQ_SINGLE_STEP_EN
    logic                  step_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) step_q <= 1'b0;
        else        step_q <= step;
    end
`endif

    // The watchdog reloads only on the entering transition, so a wait state
    // gets exactly MEM_TIMEOUT cycles including its first one.
    assign waiting = (state_q == ST_IFETCH) || (state_q == ST_MEMWAIT);
    assign to_load = ((state_d == ST_IFETCH) || (state_d == ST_MEMWAIT)) && (state_d != state_q);
    assign to_dec  = waiting;

    seq_timeout #(
        .W (TO_W)
    ) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (to_load),
        .load_val (TO_LOAD),
        .dec      (to_dec),
        .expired  (to_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_NOP;
            illegal_q <= 1'b0;
            fault_q   <= 1'b0;
            count_q   <= CNT_PRESET;
        end else begin
            state_q <= state_d;
            if (state_q == ST_DECODE) begin
                op_q <= is_legal(in_opcode) ? in_opcode : OP_NOP;
                if (!is_legal(in_opcode)) illegal_q <= 1'b1;
            end
            if (timeout_hit) fault_q <= 1'b1;
            if (state_q == ST_WB) count_q <= count_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d     = state_q;
        imem_req    = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        fetch_ce    = 1'b0;
        pc_inc      = 1'b0;
        pc_load     = 1'b0;
        alu_ce      = 1'b0;
        acc_we      = 1'b0;
        timeout_hit = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_IFETCH;
            end
            ST_IFETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    state_d = ST_LATCH;
                end else if (to_expired) begin
                    state_d     = ST_HALT;
                    timeout_hit = 1'b1;
                end
            end
            ST_LATCH: begin
                fetch_ce = 1'b1;
                pc_inc   = 1'b1;
                state_d  = ST_DECODE;
            end
            ST_DECODE: begin
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                case (op_q)
                    OP_LDA, OP_STA, OP_ADD, OP_SUB: state_d = ST_MEMWAIT;
                    OP_JMP: begin
                        pc_load = 1'b1;
                        state_d = ST_WB;
                    end
                    OP_JZ: begin
                        pc_load = acc_zero;
                        state_d = ST_WB;
                    end
                    OP_HLT:  state_d = ST_HALT;
                    default: state_d = ST_WB;
                endcase
            end
            ST_MEMWAIT: begin
                dmem_req = 1'b1;
                dmem_we  = (op_q == OP_STA);
                if (dmem_ready) begin
                    alu_ce  = (op_q == OP_ADD) || (op_q == OP_SUB);
                    acc_we  = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_LDA);
                    state_d = ST_WB;
                end else if (to_expired) begin
                    state_d     = ST_HALT;
                    timeout_hit = 1'b1;
                end
            end
            ST_WB: begin
`ifdef SEQ_SINGLE_STEP_EN
                state_d = ST_STEP_WAIT;
`else
                state_d = run ? ST_IFETCH : ST_IDLE;
`endif
            end
`ifdef SEQ_SINGLE_STEP_EN
            ST_STEP_WAIT: begin
                if (step && !step_q) state_d = ST_IFETCH;
            end
`endif
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign state       = state_q;
    assign halted      = (state_q == ST_HALT);
    assign fault       = fault_q;
    assign illegal     = illegal_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
module tb_cpu_sequencer;
    import cpu_pkg::*;

    localparam int               TIMEOUT = 15;
    localparam logic [CNT_W-1:0] PRESET  = 16'hFFF8;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                run;
    logic [OPCODE_W-1:0] in_opcode;
    logic                acc_zero;
    logic                imem_ready;
    logic                dmem_ready;
`ifdef SEQ_SINGLE_STEP_EN
    logic                step;
`endif
    logic                imem_req, dmem_req, dmem_we;
    logic                fetch_ce, pc_inc, pc_load, alu_ce, acc_we;
    logic [STATE_W-1:0]  state;
    logic                halted, fault, illegal;
    logic [CNT_W-1:0]    instr_count;

    cpu_sequencer #(
        .MEM_TIMEOUT (TIMEOUT),
        .CNT_PRESET  (PRESET)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .in_opcode   (in_opcode),
        .acc_zero    (acc_zero),
        .imem_ready  (imem_ready),
        .dmem_ready  (dmem_ready),
`ifdef SEQ_SINGLE_STEP_EN
        .step        (step),
`endif
        .imem_req    (imem_req),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .fetch_ce    (fetch_ce),
        .pc_inc      (pc_inc),
        .pc_load     (pc_load),
        .alu_ce      (alu_ce),
        .acc_we      (acc_we),
        .state       (state),
        .halted      (halted),
        .fault       (fault),
        .illegal     (illegal),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    int n_fetch, n_pcinc, n_pcl, n_alu, n_accwe, n_pair;
    int n_icyc, n_dcyc, n_we, n_excl;
    bit run_done;

    typedef struct {
        logic [3:0] op;
        logic       az;
        int         iw;
        int         dw;
        int         pcl;
        int         pair;
        int         accwe;
        bit         mem;
        bit         we;
        bit         ill;
        bit         halt;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        run        = 1'b0;
        in_opcode  = 4'h0;
        acc_zero   = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
        step       = 1'b0;
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Runs one instruction with memories that answer after iw / dw wait
    // cycles; ends after sampling the WB or HALT cycle.
    task automatic run_instr(input logic [3:0] op, input logic az, input int iw,
                             input int dw, input bit drop_run);
        int         ic;
        int         dc;
        logic [4:0] sv;
        ic = 0; dc = 0;
        n_fetch = 0; n_pcinc = 0; n_pcl = 0; n_alu = 0; n_accwe = 0; n_pair = 0;
        n_icyc = 0; n_dcyc = 0; n_we = 0; n_excl = 0; run_done = 1'b0;
        run = 1'b1;
        for (int cyc = 0; cyc < 80; cyc++) begin
            @(negedge clk);
            in_opcode  = op;
            acc_zero   = az;
            imem_ready = imem_req && (ic == iw);
            dmem_ready = dmem_req && (dc == dw);
            #1;
            if (imem_req) begin ic++; n_icyc++; end
            if (dmem_req) begin dc++; n_dcyc++; end
            if (dmem_req && dmem_we) n_we++;
            if (fetch_ce) n_fetch++;
            if (pc_inc) n_pcinc++;
            if (pc_load) n_pcl++;
            if (alu_ce) n_alu++;
            if (acc_we) n_accwe++;
            if (alu_ce && acc_we) n_pair++;
            sv = {fetch_ce, pc_inc, pc_load, alu_ce, acc_we};
            if ($countones(sv) > 1 && sv != 5'b11000 && sv != 5'b00011) n_excl++;
            if (drop_run && state == ST_LATCH) run = 1'b0;
            if (state == ST_WB || state == ST_HALT) begin
                run_done = 1'b1;
                break;
            end
        end
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        if (!run_done) chk("instr_budget", 32'd0, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [CNT_W-1:0] exp_count;
        int               n_ireq;

        vecs[0]  = '{4'h3, 1'b0, 2, 2, 0, 1, 1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{4'h1, 1'b0, 0, 0, 0, 0, 1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{4'h2, 1'b0, 1, 3, 0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{4'h4, 1'b1, 0, 1, 0, 1, 1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{4'h5, 1'b0, 0, 0, 1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{4'h6, 1'b1, 1, 0, 1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{4'h6, 1'b0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{4'h0, 1'b1, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{4'h9, 1'b0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{4'h3, 1'b0, 0, 0, 0, 1, 1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{4'hE, 1'b0, 1, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{4'hF, 1'b0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1};

        // Reset values, checked while rst_n is still low.
        rst_n = 1'b0;
        run = 1'b0; in_opcode = 4'h0; acc_zero = 1'b0;
        imem_ready = 1'b0; dmem_ready = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
        step = 1'b0;
`endif
        #12;
        chk("rst_state", 32'(state), 32'(ST_IDLE));
        chk("rst_outputs", {imem_req, dmem_req, dmem_we, fetch_ce, pc_inc, pc_load, alu_ce, acc_we},
            8'h00);
        chk("rst_flags", {halted, fault, illegal}, 3'b000);
        chk("rst_count", instr_count, PRESET);
        @(negedge clk);
        rst_n = 1'b1;

        // run low keeps the sequencer idle.
        repeat (3) @(negedge clk);
        #1;
        chk("idle_hold_state", 32'(state), 32'(ST_IDLE));
        chk("idle_hold_imem_req", imem_req, 1'b0);

        // Instruction table, back to back with run held high.
        exp_count = PRESET;
        for (int i = 0; i < 12; i++) begin
            run_instr(vecs[i].op, vecs[i].az, vecs[i].iw, vecs[i].dw, 1'b0);
            chk($sformatf("v%0d_fetch_ce", i), n_fetch, 1);
            chk($sformatf("v%0d_pc_inc", i), n_pcinc, 1);
            chk($sformatf("v%0d_ifetch_cycles", i), n_icyc, vecs[i].iw + 1);
            chk($sformatf("v%0d_pc_load", i), n_pcl, vecs[i].pcl);
            chk($sformatf("v%0d_alu_ce", i), n_alu, vecs[i].pair);
            chk($sformatf("v%0d_alu_acc_pair", i), n_pair, vecs[i].pair);
            chk($sformatf("v%0d_acc_we", i), n_accwe, vecs[i].accwe);
            chk($sformatf("v%0d_dmem_cycles", i), n_dcyc, vecs[i].mem ? vecs[i].dw + 1 : 0);
            chk($sformatf("v%0d_dmem_we_cycles", i), n_we, vecs[i].we ? vecs[i].dw + 1 : 0);
            chk($sformatf("v%0d_strobe_excl", i), n_excl, 0);
            chk($sformatf("v%0d_illegal", i), illegal, vecs[i].ill);
            chk($sformatf("v%0d_halted", i), halted, vecs[i].halt);
            if (!vecs[i].halt) begin
                @(posedge clk);
                #1;
                exp_count = exp_count + 16'd1;
                chk($sformatf("v%0d_instr_count", i), instr_count, exp_count);
                chk($sformatf("v%0d_next_state", i), 32'(state), 32'(ST_IFETCH));
            end
        end

        // HALT is terminal: no fetches with run high, count unchanged.
        n_ireq = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            imem_ready = 1'b1;
            #1;
            if (imem_req) n_ireq++;
        end
        imem_ready = 1'b0;
        chk("halt_no_imem_req", n_ireq, 0);
        chk("halt_state", 32'(state), 32'(ST_HALT));
        chk("halt_flag", halted, 1'b1);
        chk("halt_fault", fault, 1'b0);
        chk("halt_count", instr_count, exp_count);

        // STA with dmem_ready never returned: watchdog fault.
        do_reset();
        run_instr(4'h2, 1'b0, 0, 99, 1'b0);
        chk("dto_dmem_cycles", n_dcyc, TIMEOUT);
        chk("dto_state", 32'(state), 32'(ST_HALT));
        chk("dto_flags", {halted, fault, dmem_req}, 3'b110);
        repeat (3) @(negedge clk);
        #1;
        chk("dto_fault_sticky", fault, 1'b1);
        chk("dto_count", instr_count, PRESET);

        // Instruction fetch never answered: same watchdog on IFETCH.
        do_reset();
        run_instr(4'h0, 1'b0, 99, 0, 1'b0);
        chk("ito_ifetch_cycles", n_icyc, TIMEOUT);
        chk("ito_flags", {halted, fault, imem_req, fetch_ce}, 4'b1100);

        // run dropped during the instruction: it still retires, then IDLE.
        do_reset();
        run_instr(4'h3, 1'b0, 1, 1, 1'b1);
        chk("drop_pair", n_pair, 1);
        @(posedge clk);
        #1;
        chk("drop_count", instr_count, PRESET + 16'd1);
        chk("drop_state", 32'(state), 32'(ST_IDLE));
        repeat (3) @(negedge clk);
        #1;
        chk("drop_idle_no_req", {imem_req, 32'(state)}, {1'b0, 32'(ST_IDLE)});

        // Reset asserted mid-IFETCH drops imem_req without waiting for clk.
        do_reset();
        run = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("midrst_pre_req", imem_req, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_req_drop", imem_req, 1'b0);
        chk("midrst_state", 32'(state), 32'(ST_IDLE));
        chk("midrst_flags", {halted, fault, illegal}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        run   = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15, max cycles to wait for imem_ready/dmem_ready before fault.
REQ-002 clk  input  1  system clock, all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 run  input  1  level; high allows leaving IDLE and continuing execution.
REQ-005 in_opcode  input  4  opcode from fetch stage register.
REQ-006 acc_zero  input  1  accumulator-zero flag from datapath.
REQ-007 imem_req / imem_ready  output/input  1/1  instruction-memory read handshake.
REQ-008 dmem_req, dmem_we / dmem_ready  output/input  1,1/1  data-memory handshake; dmem_we high = write.
REQ-009 fetch_ce  output  1  load enable for fetch stage (opcode/address register).
REQ-010 pc_inc, pc_load  output  1 each  PC increment / load-from-address strobes.
REQ-011 alu_ce, acc_we  output  1 each  ALU operate / accumulator write strobes.
REQ-012 state  output  3  current FSM state encoding.
REQ-013 halted, fault, illegal  output  1 each  status flags.
REQ-014 instr_count  output  16  retired-instruction counter.

Function
REQ-015 States: IDLE, IFETCH, LATCH, DECODE, EXEC, MEMWAIT, WB, HALT (plus STEP_WAIT, see REQ-030).
REQ-016 IDLE -> IFETCH when run=1; else stay.
REQ-017 IFETCH: imem_req=1 held until imem_ready=1 sampled, then -> LATCH; imem_req deasserts the cycle after ready.
REQ-018 LATCH: fetch_ce=1 and pc_inc=1 for exactly one cycle, -> DECODE.
REQ-019 DECODE: one cycle; opcode 0 NOP, 1 LDA, 2 STA, 3 ADD, 4 SUB, 5 JMP, 6 JZ, F HLT; 7-E illegal -> illegal=1 (sticky), treated as NOP.
REQ-020 EXEC: LDA/STA/ADD/SUB -> MEMWAIT with dmem_req=1 (dmem_we=1 only for STA); JMP -> pc_load=1, -> WB; JZ -> pc_load=acc_zero, -> WB; NOP/illegal -> WB; HLT -> HALT.
REQ-021 MEMWAIT: hold dmem_req/dmem_we until dmem_ready; on ready: ADD/SUB assert alu_ce=1 and acc_we=1, LDA asserts acc_we=1, STA neither; then -> WB.
REQ-022 WB: instr_count increments by 1 (wraps 0xFFFF -> 0x0000), then -> IFETCH if run=1, else IDLE.
REQ-023 HALT: halted=1, no strobes; leave only by reset. HLT does not increment instr_count.
REQ-024 Timeout: counter reloads on entering IFETCH/MEMWAIT; if ready not seen within MEM_TIMEOUT cycles -> HALT with fault=1 (sticky).
REQ-025 run dropping mid-instruction does not abort; the instruction completes through WB.
REQ-026 All strobes (fetch_ce, pc_inc, pc_load, alu_ce, acc_we) are single-cycle pulses, mutually exclusive except LATCH (fetch_ce+pc_inc) and ADD/SUB completion (alu_ce+acc_we).
REQ-027 Ready arriving in the same cycle as req first asserts is accepted (zero-wait memory: IFETCH lasts 1 cycle).

Reset
REQ-028 rst_n low asynchronously forces state=IDLE, all strobes and req outputs 0, halted=fault=illegal=0, instr_count=0, timeout counter=0.
REQ-029 Reset asserted mid-handshake drops req immediately; the pending transaction is abandoned.

Configuration
REQ-030 Macro SEQ_SINGLE_STEP_EN: when defined, adds input step (1 bit); WB -> STEP_WAIT, which holds until a rising edge of step, then -> IFETCH; undefined: no step port, no STEP_WAIT state, WB follows REQ-022.

Structure
REQ-031 Shared package cpu_pkg holds opcode constants, state enumeration, and widths (OPCODE_W=4, ADDR_W=12, CNT_W=16).
REQ-032 One sub-module seq_timeout (loadable down-counter with expire flag) is instantiated for REQ-024; all else is in cpu_sequencer.

Verification
REQ-033 Reset, run=1, opcode 3 (ADD), imem/dmem ready after 2 cycles -> fetch_ce once, alu_ce+acc_we same cycle, instr_count=1.
REQ-034 Opcode 6 with acc_zero=1 -> pc_load pulse; with acc_zero=0 -> no pc_load; both retire (count +1).
REQ-035 Opcode F -> halted=1, state=HALT, no further imem_req for 20 cycles with run=1.
REQ-036 dmem_ready held 0 for 16 cycles during STA -> fault=1, halted=1, dmem_req=0.
REQ-037 Opcode 9 -> illegal=1, no memory access, instr_count increments; rst_n pulsed low mid-IFETCH -> imem_req=0 same cycle, state=IDLE.
REQ-038 Preset instr_count path: 65536 NOPs -> instr_count wraps to 0x0000.
